// File: rtl/decode_stage_buf.sv
// LEGv8 decode stage with a 2-entry elastic FIFO between fetch and execute.
// Instructions are decoded on entry; every output is read from the head entry's registers.
module decode_stage_buf #(
   parameter int INSTR_LEN = 32,
   parameter int PC_W      = 64,
   parameter int DATA_W    = 64
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 flush,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [INSTR_LEN-1:0] instruction,
   input  logic [PC_W-1:0]      pc_in,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [10:0]          opcode,
   output logic [4:0]           rm_num,
   output logic [4:0]           rn_num,
   output logic [4:0]           rd_num,
   output logic [8:0]           address,
   output logic [2:0]           format,
   output logic [DATA_W-1:0]    imm,
   output logic [PC_W-1:0]      pc_out,
   output logic [PC_W-1:0]      branch_target
);

   typedef enum logic [2:0] {
      FMT_R  = 3'd0,
      FMT_I  = 3'd1,
      FMT_D  = 3'd2,
      FMT_B  = 3'd3,
      FMT_CB = 3'd4,
      FMT_IM = 3'd5
   } fmt_e;

   typedef struct packed {
      logic [10:0]       opcode;
      logic [4:0]        rm;
      logic [4:0]        rn;
      logic [4:0]        rd;
      logic [8:0]        address;
      fmt_e              fmt;
      logic [DATA_W-1:0] imm;
      logic [PC_W-1:0]   pc;
      logic [PC_W-1:0]   target;
   } entry_t;

   entry_t     mem [2];
   entry_t     dec;
   fmt_e       dec_fmt;
   logic [DATA_W-1:0] dec_imm;
   logic       head;
   logic       tail;
   logic [1:0] count;
   logic       push;
   logic       pop;

   // Handshake: a beat transfers on a rising edge where valid && ready; producers
   // hold their data while valid is high and ready is low. Flush drops both sides.
   assign in_ready  = (count != 2'd2);
   assign out_valid = (count != 2'd0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   always_comb begin
      dec_fmt = FMT_R;
      if (instruction[31:26] == 6'b000101 || instruction[31:26] == 6'b100101)
         dec_fmt = FMT_B;
      else if (instruction[31:24] == 8'hB4 || instruction[31:24] == 8'hB5 ||
               instruction[31:24] == 8'h54)
         dec_fmt = FMT_CB;
      else if (instruction[29:24] == 6'b111000)
         dec_fmt = FMT_D;
      else if (instruction[28:24] == 5'b10001)
         dec_fmt = FMT_I;
      else if (instruction[28:23] == 6'b100101)
         dec_fmt = FMT_IM;

      dec_imm = '0;
      unique case (dec_fmt)
         FMT_D:   dec_imm = {{(DATA_W-9){instruction[20]}}, instruction[20:12]};
         FMT_B:   dec_imm = {{(DATA_W-26){instruction[25]}}, instruction[25:0]};
         FMT_CB:  dec_imm = {{(DATA_W-19){instruction[23]}}, instruction[23:5]};
         FMT_I:   dec_imm = DATA_W'(instruction[21:10]);
         FMT_IM:  dec_imm = DATA_W'(instruction[20:5]);
         default: dec_imm = DATA_W'(instruction[15:10]);
      endcase

      dec         = '0;
      dec.opcode  = instruction[31:21];
      dec.rm      = instruction[20:16];
      dec.rn      = instruction[9:5];
      dec.rd      = instruction[4:0];
      dec.address = instruction[20:12];
      dec.fmt     = dec_fmt;
      dec.imm     = dec_imm;
      dec.pc      = pc_in;
      // Word offset; wraps modulo 2^PC_W.
      dec.target  = pc_in + (PC_W'(dec_imm) << 2);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head   <= 1'b0;
         tail   <= 1'b0;
         count  <= 2'd0;
         mem[0] <= '0;
         mem[1] <= '0;
      end else if (flush) begin
         head  <= 1'b0;
         tail  <= 1'b0;
         count <= 2'd0;
      end else begin
         if (push) begin
            mem[tail] <= dec;
            tail      <= ~tail;
         end
         if (pop)
            head <= ~head;
         if (push && !pop)
            count <= count + 2'd1;
         else if (pop && !push)
            count <= count - 2'd1;
      end
   end

   assign opcode        = mem[head].opcode;
   assign rm_num        = mem[head].rm;
   assign rn_num        = mem[head].rn;
   assign rd_num        = mem[head].rd;
   assign address       = mem[head].address;
   assign format        = mem[head].fmt;
   assign imm           = mem[head].imm;
   assign pc_out        = mem[head].pc;
   assign branch_target = mem[head].target;

endmodule
